// File: rtl/cart_ram_controller.sv
// cart_ram_controller: sequences the 64 KiB console RAM between the HPS
// cartridge loader and the console CPU, zero-fills the unloaded tail after
// every download and holds the CPU in reset until the RAM image is complete.
// Optional feature macro: CART_RAM_WP_EN (CPU writes at or below ROM_TOP are
// suppressed while running).
module cart_ram_controller #(
  parameter int unsigned HOLD_CYCLES = 255,
  parameter logic [7:0]  FILL_BYTE   = 8'h00,
  parameter logic [15:0] ROM_TOP     = 16'h7FFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] cpu_a,
  input  logic        cpu_ce_n,
  input  logic        cpu_we_n,
  input  logic [7:0]  cpu_d_i,
  output logic [7:0]  cpu_d_o,
  output logic        cpu_rd_valid,
  output logic        cpu_reset_o,
  output logic [15:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q,
  output logic [16:0] load_len,
  output logic        load_ovf,
  output logic        busy
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [1:0]  state;
  logic [15:0] fill_ptr;
  logic [31:0] hold_cnt;
  logic        rd_pend;
  logic        ioctl_in_win;
  logic [16:0] wr_end;
  logic [16:0] len_next;
  logic        cpu_wr_ok;

  assign ioctl_in_win = (ioctl_addr[24:16] == 9'd0);
  assign wr_end       = {1'b0, ioctl_addr[15:0]} + 17'd1;

  assign busy        = (state != ST_RUN);
  assign cpu_reset_o = busy;

`ifdef CART_RAM_WP_EN
  assign cpu_wr_ok = (cpu_a > ROM_TOP);
`else
  logic unused_rom_top;
  assign unused_rom_top = ^ROM_TOP;
  assign cpu_wr_ok      = 1'b1;
`endif

  // Running high-water mark of the download, including the write in flight
  always_comb begin
    len_next = load_len;
    if (ioctl_wr && ioctl_in_win && (wr_end > load_len))
      len_next = wr_end;
  end

  // RAM port mux: whoever owns the current state drives the spram directly
  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    ram_we = 1'b0;
    case (state)
      ST_LOAD: begin
        ram_a  = ioctl_addr[15:0];
        ram_d  = ioctl_dout;
        ram_we = ioctl_wr & ioctl_in_win;
      end
      ST_FILL: begin
        ram_a  = fill_ptr;
        ram_d  = FILL_BYTE;
        ram_we = 1'b1;
      end
      ST_RUN: begin
        ram_a  = cpu_a;
        ram_d  = cpu_d_i;
        ram_we = ~cpu_ce_n & ~cpu_we_n & cpu_wr_ok;
      end
      default: ;
    endcase
  end

  // Sequencer: download always wins; otherwise LOAD -> FILL -> HOLD -> RUN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= ST_HOLD;
      hold_cnt <= HOLD_CYCLES;
      fill_ptr <= '0;
      load_len <= '0;
      load_ovf <= 1'b0;
    end else if (ioctl_download) begin
      if (state != ST_LOAD) begin
        state    <= ST_LOAD;
        load_len <= '0;
        load_ovf <= 1'b0;
      end else begin
        load_len <= len_next;
        if (ioctl_wr && !ioctl_in_win)
          load_ovf <= 1'b1;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          load_len <= len_next;
          if (ioctl_wr && !ioctl_in_win)
            load_ovf <= 1'b1;
          // A full 64 KiB image has no tail to clear
          if (len_next[16]) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_CYCLES;
          end else begin
            state    <= ST_FILL;
            fill_ptr <= len_next[15:0];
          end
        end
        ST_FILL: begin
          fill_ptr <= fill_ptr + 16'd1;
          if (fill_ptr == 16'hFFFF) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_CYCLES;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 32'd0)
            state <= ST_RUN;
          else
            hold_cnt <= hold_cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

  // CPU read pipeline: one cycle for the spram, one for the output register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_pend      <= 1'b0;
      cpu_d_o      <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      rd_pend      <= (state == ST_RUN) & ~cpu_ce_n & cpu_we_n;
      cpu_rd_valid <= rd_pend & (state == ST_RUN);
      if (rd_pend && (state == ST_RUN))
        cpu_d_o <= ram_q;
    end
  end

endmodule

// File: tb/tb_cart_ram_controller.sv
// Directed/randomized bench for cart_ram_controller with a behavioural
// RAM-image reference model and a one-cycle-latency spram model.
module tb_cart_ram_controller;

  localparam int unsigned HOLD = 255;
  localparam logic [7:0]  FILL = 8'h00;
  localparam logic [15:0] RTOP = 16'h7FFF;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] cpu_a;
  logic        cpu_ce_n;
  logic        cpu_we_n;
  logic [7:0]  cpu_d_i;
  logic [7:0]  cpu_d_o;
  logic        cpu_rd_valid;
  logic        cpu_reset_o;
  logic [15:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic [16:0] load_len;
  logic        load_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int unsigned exp_len;

  always #5 clk_sys = ~clk_sys;

  // spram model: synchronous write, registered read
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  cart_ram_controller #(
    .HOLD_CYCLES(HOLD),
    .FILL_BYTE(FILL),
    .ROM_TOP(RTOP)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_a(cpu_a), .cpu_ce_n(cpu_ce_n), .cpu_we_n(cpu_we_n),
    .cpu_d_i(cpu_d_i), .cpu_d_o(cpu_d_o), .cpu_rd_valid(cpu_rd_valid),
    .cpu_reset_o(cpu_reset_o),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
    .load_len(load_len), .load_ovf(load_ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cpu_may_write(input logic [15:0] a);
`ifdef CART_RAM_WP_EN
    return a > RTOP;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One loader byte; the model records it only if it lands inside 64 KiB
  task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    #1;
    chk("ioctl_ram_we", ram_we, (a < 25'h10000) ? 1 : 0);
    if (a < 25'h10000) begin
      ref_mem[a[15:0]] = d;
      if (int'(a) + 1 > exp_len) exp_len = int'(a) + 1;
    end
    tick();
    ioctl_wr = 1'b0;
    chk("load_rd_valid", cpu_rd_valid, 0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok       = cpu_may_write(a);
    cpu_a    = a;
    cpu_d_i  = d;
    cpu_ce_n = 1'b0;
    cpu_we_n = 1'b0;
    #1;
    chk("cpu_ram_we", ram_we, ok ? 1 : 0);
    if (ok) ref_mem[a] = d;
    tick();
    cpu_ce_n = 1'b1;
    cpu_we_n = 1'b1;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a);
    cpu_a    = a;
    cpu_ce_n = 1'b0;
    cpu_we_n = 1'b1;
    tick();
    cpu_ce_n = 1'b1;
    chk("rd_valid_early", cpu_rd_valid, 0);
    tick();
    chk("rd_valid", cpu_rd_valid, 1);
    chk(tag, cpu_d_o, ref_mem[a]);
  endtask

  // Count edges until cpu_reset_o falls, bounded
  task automatic wait_run(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_reset_o === 1'b1 && n < 70000);
  endtask

  initial begin
    int unsigned n;
    int unsigned na;
    logic [24:0] a;
    logic [15:0] ra;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    cpu_a          = '0;
    cpu_ce_n       = 1'b1;
    cpu_we_n       = 1'b1;
    cpu_d_i        = '0;
    exp_len        = 0;

    // Reset values
    #3;
    chk("rst_cpu_reset", cpu_reset_o, 1);
    chk("rst_busy", busy, 1);
    chk("rst_load_len", load_len, 0);
    chk("rst_load_ovf", load_ovf, 0);
    chk("rst_cpu_d_o", cpu_d_o, 0);
    chk("rst_rd_valid", cpu_rd_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);

    // Power-up hold with no download
    tick();
    tick();
    reset = 1'b0;
    wait_run(n);
    chk("powerup_hold_cycles", n, HOLD + 1);
    chk("powerup_busy", busy, 0);

    // Download A: random bytes in 0..15, CPU reads attempted throughout, then
    // one out-of-window byte
    ioctl_download = 1'b1;
    tick();
    chk("loadA_cpu_reset", cpu_reset_o, 1);
    chk("loadA_busy", busy, 1);
    chk("loadA_len_clear", load_len, 0);
    cpu_ce_n = 1'b0;
    cpu_we_n = 1'b1;
    na = $urandom_range(6, 16);
    for (int i = 0; i < int'(na); i++) begin
      a = 25'($urandom_range(0, 15));
      ioctl_write(a, 8'($urandom));
    end
    ra = 16'($urandom_range(0, 15));
    ioctl_write(25'h10000 | 25'(ra), 8'($urandom));
    cpu_ce_n = 1'b1;
    chk("loadA_len", load_len, exp_len);
    chk("loadA_ovf", load_ovf, 1);
    chk("loadA_no_wrap", mem[ra], ref_mem[ra]);
    chk("loadA_mem0", mem[0], ref_mem[0]);

    // Let FILL run briefly, then restart a download on top of it
    ioctl_download = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("fillA_cpu_reset", cpu_reset_o, 1);
    chk("fillA_busy", busy, 1);
    chk("fillA_len_kept", load_len, exp_len);
    ioctl_download = 1'b1;
    tick();
    chk("abort_len_clear", load_len, 0);
    chk("abort_ovf_clear", load_ovf, 0);
    chk("abort_cpu_reset", cpu_reset_o, 1);
    chk("abort_busy", busy, 1);

    // Download B: AA BB CC DD at 0..3, then full tail fill and hold
    exp_len = 0;
    ioctl_write(25'h0, 8'hAA);
    ioctl_write(25'h1, 8'hBB);
    ioctl_write(25'h2, 8'hCC);
    ioctl_write(25'h3, 8'hDD);
    chk("loadB_len", load_len, exp_len);
    chk("loadB_ovf", load_ovf, 0);
    ioctl_download = 1'b0;
    wait_run(n);
    chk("loadB_fill_hold_cycles", n, (65536 - exp_len) + HOLD + 2);
    chk("loadB_busy", busy, 0);
    for (int unsigned i = exp_len; i < 65536; i++) ref_mem[i] = FILL;

    // RUN: loaded bytes, cleared stale bytes and top address
    for (int i = 0; i < 18; i++) cpu_read("run_rd_low", 16'(i));
    cpu_read("run_rd_top", 16'hFFFF);

    cpu_write(16'h8000, 8'h5A);
    cpu_read("run_rd_8000", 16'h8000);

    // Loader strobe outside a download must not touch RAM
    ioctl_addr = 25'h8000;
    ioctl_dout = 8'h99;
    ioctl_wr   = 1'b1;
    #1;
    chk("run_stray_ioctl_we", ram_we, 0);
    tick();
    ioctl_wr = 1'b0;
    cpu_read("run_rd_8000_after_stray", 16'h8000);

    cpu_write(16'h0010, 8'h77);
    cpu_read("run_rd_0010", 16'h0010);

    // Random CPU traffic against the image model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) cpu_write(ra, 8'($urandom));
      else cpu_read("run_rd_rand", ra);
    end
    chk("run_cpu_reset_end", cpu_reset_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
